// File: rtl/coherence_pkg.sv
// Shared MSI coherence definitions used by the snoop responder and the CPU-side controller.
package coherence_pkg;

    localparam logic [1:0] ST_INVALID  = 2'b00;
    localparam logic [1:0] ST_SHARED   = 2'b01;
    localparam logic [1:0] ST_MODIFIED = 2'b10;

    localparam logic [1:0] OP_NONE    = 2'b00;
    localparam logic [1:0] OP_RD_MISS = 2'b01;
    localparam logic [1:0] OP_WR_MISS = 2'b10;
    localparam logic [1:0] OP_INV     = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB,
        S_UPDATE
    } snp_fsm_t;

    // Encoding 11 is illegal and must never produce a hit.
    function automatic logic line_valid(input logic [1:0] st);
        return (st == ST_SHARED) || (st == ST_MODIFIED);
    endfunction

    // State a hit line ends in: a remote read leaves a copy, anything else removes it.
    function automatic logic [1:0] snoop_next_state(input logic [1:0] op);
        return (op == OP_RD_MISS) ? ST_SHARED : ST_INVALID;
    endfunction

endpackage

// File: rtl/snoop_responder_line_table.sv
// Per-line state/tag table: two combinational read ports, two write ports, snoop write wins.
module line_table
    import coherence_pkg::*;
#(
    parameter int LINES = 4,
    parameter int TAG_W = 6,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [IDX_W-1:0] cpu_rd_index,
    output logic [1:0]       cpu_rd_state,
    output logic [TAG_W-1:0] cpu_rd_tag,
    input  logic [IDX_W-1:0] snp_rd_index,
    output logic [1:0]       snp_rd_state,
    output logic [TAG_W-1:0] snp_rd_tag,
    input  logic             cpu_wr_en,
    input  logic [IDX_W-1:0] cpu_wr_index,
    input  logic [TAG_W-1:0] cpu_wr_tag,
    input  logic [1:0]       cpu_wr_state,
    input  logic             snp_wr_en,
    input  logic [IDX_W-1:0] snp_wr_index,
    input  logic [TAG_W-1:0] snp_wr_tag,
    input  logic [1:0]       snp_wr_state,
    output logic             cpu_conflict
);

    logic [1:0]       state_reg [LINES];
    logic [TAG_W-1:0] tag_reg   [LINES];
    logic [LINES-1:0] snp_sel;
    logic [LINES-1:0] cpu_sel;
    logic             conflict_reg;

    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_sel
            assign snp_sel[gi] = snp_wr_en && (snp_wr_index == IDX_W'(gi));
            assign cpu_sel[gi] = cpu_wr_en && (cpu_wr_index == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < LINES; i++) begin
                state_reg[i] <= ST_INVALID;
                tag_reg[i]   <= '0;
            end
            conflict_reg <= 1'b0;
        end else begin
            for (int i = 0; i < LINES; i++) begin
                if (snp_sel[i]) begin
                    state_reg[i] <= snp_wr_state;
                    tag_reg[i]   <= snp_wr_tag;
                end else if (cpu_sel[i]) begin
                    state_reg[i] <= cpu_wr_state;
                    tag_reg[i]   <= cpu_wr_tag;
                end
            end
            conflict_reg <= |(snp_sel & cpu_sel);
        end
    end

    assign cpu_rd_state = state_reg[cpu_rd_index];
    assign cpu_rd_tag   = tag_reg[cpu_rd_index];
    assign snp_rd_state = state_reg[snp_rd_index];
    assign snp_rd_tag   = tag_reg[snp_rd_index];
    assign cpu_conflict = conflict_reg;

endmodule

// File: rtl/snoop_responder.sv
// Bus-side MSI snoop responder: looks up snooped lines, writes back Modified hits, downgrades.
module snoop_responder
    import coherence_pkg::*;
#(
    parameter int LINES = 4,
    parameter int TAG_W = 6,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   snp_valid,
    output logic                   snp_ready,
    input  logic [1:0]             snp_op,
    input  logic [TAG_W+IDX_W-1:0] snp_addr,
    output logic                   snp_done,
    output logic                   snp_hit,
    output logic                   snp_wb,
    output logic                   abort_mem,
    output logic                   wb_req,
    output logic [IDX_W-1:0]       wb_index,
    input  logic                   wb_ack,
    output logic                   proto_err,
    input  logic [IDX_W-1:0]       cpu_rd_index,
    output logic [1:0]             cpu_rd_state,
    output logic [TAG_W-1:0]       cpu_rd_tag,
    input  logic                   cpu_upd_valid,
    input  logic [IDX_W-1:0]       cpu_upd_index,
    input  logic [TAG_W-1:0]       cpu_upd_tag,
    input  logic [1:0]             cpu_upd_state,
    output logic                   cpu_upd_conflict
);

    snp_fsm_t         state_reg, state_next;
    logic [1:0]       op_reg;
    logic [TAG_W-1:0] tag_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             hit_reg;
    logic [1:0]       new_state_reg;

    logic ready_reg, ready_next;
    logic done_reg, done_next;
    logic hit_out_reg, hit_out_next;
    logic wb_out_reg, wb_out_next;
    logic abort_reg, abort_next;
    logic wb_req_reg, wb_req_next;
    logic proto_reg, proto_next;
    logic [IDX_W-1:0] wb_index_reg;

    logic [1:0]       lk_state;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic             lk_wb;
    logic             accept;

    line_table #(.LINES(LINES), .TAG_W(TAG_W), .IDX_W(IDX_W)) u_table (
        .clock        (clock),
        .resetn       (resetn),
        .cpu_rd_index (cpu_rd_index),
        .cpu_rd_state (cpu_rd_state),
        .cpu_rd_tag   (cpu_rd_tag),
        .snp_rd_index (idx_reg),
        .snp_rd_state (lk_state),
        .snp_rd_tag   (lk_tag),
        .cpu_wr_en    (cpu_upd_valid),
        .cpu_wr_index (cpu_upd_index),
        .cpu_wr_tag   (cpu_upd_tag),
        .cpu_wr_state (cpu_upd_state),
        .snp_wr_en    (state_reg == S_UPDATE && hit_reg),
        .snp_wr_index (idx_reg),
        .snp_wr_tag   (tag_reg),
        .snp_wr_state (new_state_reg),
        .cpu_conflict (cpu_upd_conflict)
    );

    assign accept = snp_valid && ready_reg;
    assign lk_hit = (op_reg != OP_NONE) && (lk_tag == tag_reg) && line_valid(lk_state);
    assign lk_wb  = lk_hit && (lk_state == ST_MODIFIED);

    // Output flops are loaded from the transition so each pulse lands in the state it belongs to.
    always_comb begin
        state_next   = state_reg;
        ready_next   = 1'b0;
        done_next    = 1'b0;
        hit_out_next = 1'b0;
        wb_out_next  = 1'b0;
        abort_next   = 1'b0;
        wb_req_next  = 1'b0;
        proto_next   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (accept) state_next = S_LOOKUP;
                else        ready_next = 1'b1;
            end
            S_LOOKUP: begin
                if (lk_wb) begin
                    state_next  = S_WB;
                    wb_req_next = 1'b1;
                    abort_next  = 1'b1;
                    proto_next  = (op_reg == OP_INV);
                end else begin
                    state_next   = S_UPDATE;
                    done_next    = 1'b1;
                    hit_out_next = lk_hit;
                end
            end
            S_WB: begin
                if (wb_ack) begin
                    state_next   = S_UPDATE;
                    done_next    = 1'b1;
                    hit_out_next = hit_reg;
                    wb_out_next  = 1'b1;
                end else begin
                    wb_req_next = 1'b1;
                end
            end
            S_UPDATE: begin
                state_next = S_IDLE;
                ready_next = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
                ready_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg     <= S_IDLE;
            ready_reg     <= 1'b1;
            done_reg      <= 1'b0;
            hit_out_reg   <= 1'b0;
            wb_out_reg    <= 1'b0;
            abort_reg     <= 1'b0;
            wb_req_reg    <= 1'b0;
            proto_reg     <= 1'b0;
            wb_index_reg  <= '0;
            op_reg        <= OP_NONE;
            tag_reg       <= '0;
            idx_reg       <= '0;
            hit_reg       <= 1'b0;
            new_state_reg <= ST_INVALID;
        end else begin
            state_reg   <= state_next;
            ready_reg   <= ready_next;
            done_reg    <= done_next;
            hit_out_reg <= hit_out_next;
            wb_out_reg  <= wb_out_next;
            abort_reg   <= abort_next;
            wb_req_reg  <= wb_req_next;
            proto_reg   <= proto_next;
            if (state_reg == S_IDLE && accept) begin
                op_reg  <= snp_op;
                tag_reg <= snp_addr[TAG_W+IDX_W-1:IDX_W];
                idx_reg <= snp_addr[IDX_W-1:0];
            end
            // The result is frozen here so CPU writes during WB cannot change the outcome.
            if (state_reg == S_LOOKUP) begin
                hit_reg       <= lk_hit;
                new_state_reg <= snoop_next_state(op_reg);
                if (lk_wb) wb_index_reg <= idx_reg;
            end
        end
    end

    assign snp_ready = ready_reg;
    assign snp_done  = done_reg;
    assign snp_hit   = hit_out_reg;
    assign snp_wb    = wb_out_reg;
    assign abort_mem = abort_reg;
    assign wb_req    = wb_req_reg;
    assign wb_index  = wb_index_reg;
    assign proto_err = proto_reg;

endmodule
